fpu_ctrl: RTL and testbench

FPU_CTRL -- requirements
Module: fpu_ctrl

---
 rtl/fpu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fpu_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ctrl.sv
// Sequencing controller for a multi-cycle FPU: issues one op, times it, returns the result.
// Define FPU_DIV_SQRT_EN to execute FDIV/FSQRT; otherwise those codes complete as illegal.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; an accepted start latches op and operands
// S_EXEC | unit busy; cnt counts down to the final execution cycle
// S_DONE | one-cycle done pulse; result and illegal are valid
module fpu_ctrl #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 10,
  parameter int LAT_CVT  = 1,
  parameter int LAT_CMP  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [3:0]  fpucontrol,
  input  logic        fpusrca,
  input  logic        mode,
  input  logic [31:0] fsrca,
  input  logic [31:0] isrca,
  input  logic [31:0] fsrcb,
  output logic [3:0]  unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        unit_mode,
  input  logic [31:0] unit_result,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_ADD  = 4'(LAT_ADD - 1);
  localparam logic [3:0] CNT_MUL  = 4'(LAT_MUL - 1);
  localparam logic [3:0] CNT_DIV  = 4'(LAT_DIV - 1);
  localparam logic [3:0] CNT_SQRT = 4'(LAT_SQRT - 1);
  localparam logic [3:0] CNT_CVT  = 4'(LAT_CVT - 1);
  localparam logic [3:0] CNT_CMP  = 4'(LAT_CMP - 1);

  logic [1:0]  state_q,   state_d;
  logic [3:0]  cnt_q,     cnt_d;
  logic [3:0]  op_q,      op_d;
  logic [31:0] a_q,       a_d;
  logic [31:0] b_q,       b_d;
  logic        mode_q,    mode_d;
  logic [31:0] result_q,  result_d;
  logic        illegal_q, illegal_d;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      4'b0000, 4'b0001, 4'b0010,
      4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1001:           ok = 1'b1;
`ifdef FPU_DIV_SQRT_EN
      4'b0011, 4'b0100:           ok = 1'b1;
`else
      4'b0011, 4'b0100:           ok = 1'b0;
`endif
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Initial countdown value; unsupported ops spend a single cycle in EXEC.
  function automatic logic [3:0] op_cnt(input logic [3:0] op);
    logic [3:0] c;
    case (op)
      4'b0000, 4'b0001:           c = CNT_ADD;
      4'b0010:                    c = CNT_MUL;
`ifdef FPU_DIV_SQRT_EN
      4'b0011:                    c = CNT_DIV;
      4'b0100:                    c = CNT_SQRT;
`else
      4'b0011, 4'b0100:           c = 4'd0;
`endif
      4'b0101, 4'b1001:           c = CNT_CVT;
      4'b0110, 4'b0111, 4'b1000:  c = CNT_CMP;
      default:                    c = 4'd0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    stall     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall   = 1'b1;
          op_d    = fpucontrol;
          a_d     = fpusrca ? isrca : fsrca;
          b_d     = fsrcb;
          mode_d  = mode;
          cnt_d   = op_cnt(fpucontrol);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          if (op_legal(op_q)) begin
            result_d  = unit_result;
            illegal_d = 1'b0;
          end else begin
            result_d  = 32'd0;
            illegal_d = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      op_q      <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      mode_q    <= 1'b0;
      result_q  <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign done      = (state_q == S_DONE);
  assign unit_op   = op_q;
  assign unit_a    = a_q;
  assign unit_b    = b_q;
  assign unit_mode = mode_q;
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_fpu_ctrl.sv
// Randomized self-checking bench for fpu_ctrl against a cycle-count reference model.
module tb_fpu_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  fpucontrol = 4'd0;
  logic        fpusrca = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] fsrca = 32'd0;
  logic [31:0] isrca = 32'd0;
  logic [31:0] fsrcb = 32'd0;
  logic [31:0] unit_result = 32'd0;
  logic [3:0]  unit_op;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        unit_mode;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  // Expected contents of the result/illegal registers from the last completion.
  logic [31:0] m_result = 32'd0;
  logic        m_illegal = 1'b0;

  logic [3:0]  b_op[6];
  logic [31:0] b_a[6];
  logic [31:0] b_res[6];

  always #5 clk = ~clk;

  fpu_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .fpucontrol(fpucontrol),
    .fpusrca(fpusrca), .mode(mode), .fsrca(fsrca), .isrca(isrca), .fsrcb(fsrcb),
    .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b), .unit_mode(unit_mode),
    .unit_result(unit_result), .stall(stall), .done(done), .result(result),
    .illegal(illegal)
  );

  // Execution latency per op code with default parameters; 0 means unsupported.
  function automatic int model_lat(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: return 2;
      4'd2:       return 2;
`ifdef FPU_DIV_SQRT_EN
      4'd3, 4'd4: return 10;
`endif
      4'd5, 4'd9: return 1;
      4'd6, 4'd7, 4'd8: return 1;
      default:    return 0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic sel, input logic md,
                        input logic [31:0] fa, input logic [31:0] ia,
                        input logic [31:0] fb, input logic [31:0] res,
                        input bit noisy, input string tag);
    int          l;
    bit          ill;
    int          ndone;
    logic [31:0] exp_a;
    logic [31:0] exp_r;
    l     = model_lat(op);
    ill   = (l == 0);
    if (ill) l = 1;
    exp_a = sel ? ia : fa;
    exp_r = ill ? 32'd0 : res;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; fpucontrol = op; fpusrca = sel; mode = md;
    fsrca = fa; isrca = ia; fsrcb = fb; unit_result = $urandom;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL %s issue_stall got=%b exp=1", tag, stall);
    end
    for (int c = 1; c <= l + 2; c++) begin
      @(negedge clk);
      if (noisy && c <= l + 1) begin
        start = 1'($urandom); fpucontrol = 4'($urandom); fpusrca = 1'($urandom);
        mode = 1'($urandom); fsrca = $urandom; isrca = $urandom; fsrcb = $urandom;
      end else begin
        start = 1'b0;
      end
      unit_result = (c == l) ? res : $urandom;
      #1;
      ndone += int'(done);
      checks++;
      if (stall !== (c <= l)) begin
        failures++; $display("FAIL %s stall c=%0d got=%b exp=%b", tag, c, stall, (c <= l));
      end
      checks++;
      if (done !== (c == l + 1)) begin
        failures++; $display("FAIL %s done c=%0d got=%b exp=%b", tag, c, done, (c == l + 1));
      end
      if (c <= l) begin
        checks++;
        if (unit_op !== op || unit_a !== exp_a || unit_b !== fb || unit_mode !== md) begin
          failures++;
          $display("FAIL %s unit_ports c=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b",
                   tag, c, unit_op, unit_a, unit_b, unit_mode, op, exp_a, fb, md);
        end
        checks++;
        if (result !== m_result || illegal !== m_illegal) begin
          failures++;
          $display("FAIL %s result_hold c=%0d got=%h/%b exp=%h/%b",
                   tag, c, result, illegal, m_result, m_illegal);
        end
      end else begin
        checks++;
        if (result !== exp_r || illegal !== ill) begin
          failures++;
          $display("FAIL %s result c=%0d got=%h/%b exp=%h/%b", tag, c, result, illegal, exp_r, ill);
        end
      end
    end
    checks++;
    if (ndone != 1) begin
      failures++; $display("FAIL %s done_count got=%0d exp=1", tag, ndone);
    end
    m_result  = exp_r;
    m_illegal = ill;
  endtask

  task automatic check_zero_state(input string tag);
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0 || illegal !== 1'b0 ||
        unit_op !== 4'd0 || unit_a !== 32'd0 || unit_b !== 32'd0 || unit_mode !== 1'b0) begin
      failures++;
      $display("FAIL %s got stall=%b done=%b res=%h ill=%b op=%h a=%h b=%h m=%b exp all zero",
               tag, stall, done, result, illegal, unit_op, unit_a, unit_b, unit_mode);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_zero_state("reset_values");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_release got stall=%b done=%b exp=0/0", stall, done);
    end
  endtask

  task automatic test_fadd();
    run_op(4'b0000, 1'b0, 1'b0, 32'h3F800000, 32'h12345678, 32'h40000000, 32'h40400000, 1'b0, "fadd");
  endtask

  task automatic test_fcvt();
    run_op(4'b1001, 1'b1, 1'b1, 32'hDEADBEEF, 32'h00000005, 32'h0, 32'h40A00000, 1'b0, "fcvt_sw");
  endtask

  task automatic test_illegal();
    run_op(4'b1100, 1'b0, 1'b0, 32'h1, 32'h2, 32'h3, 32'hCAFEF00D, 1'b0, "illegal_1100");
    run_op(4'b0011, 1'b0, 1'b0, 32'h41200000, 32'h0, 32'h40000000, 32'h40A00000, 1'b0, "fdiv_code");
  endtask

  task automatic test_ignored_starts();
    run_op(4'b0011, 1'b0, 1'b0, 32'h41200000, 32'h0, 32'h40000000, 32'h40A00000, 1'b1, "fdiv_noisy");
    run_op(4'b0010, 1'b1, 1'b0, 32'h0, 32'h7, 32'h40400000, 32'h41A80000, 1'b1, "fmul_noisy");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), $urandom, $urandom,
             $urandom, $urandom, bit'($urandom), "random");
    end
  endtask

  task automatic test_reset_abort();
    int k;
    int ndone;
    logic [3:0] op;
`ifdef FPU_DIV_SQRT_EN
    op = 4'b0011; k = 5;
`else
    op = 4'b0000; k = 1;
`endif
    ndone = 0;
    run_op(4'b0001, 1'b0, 1'b0, 32'h40000000, 32'h0, 32'h3F800000, 32'h3F800000, 1'b0, "pre_abort");
    @(negedge clk);
    start = 1'b1; fpucontrol = op; fpusrca = 1'b0; fsrca = 32'hAAAA5555; fsrcb = 32'h5555AAAA;
    mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (k - 1) @(negedge clk);
    unit_result = 32'hFFFFFFFF;
    rstn = 1'b0;
    #1 check_zero_state("abort_in_reset");
    m_result  = 32'd0;
    m_illegal = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      #1 ndone += int'(done);
    end
    checks++;
    if (ndone != 0 || result !== 32'd0) begin
      failures++; $display("FAIL abort_after got dones=%0d result=%h exp=0/0", ndone, result);
    end
  endtask

  task automatic test_back_to_back();
    int n = 6;
    int idx = 0;
    int issue_cyc = 0;
    int total = 0;
    int ndone = 0;
    int l;
    int rel;
    bit ill;
    for (int i = 0; i < n; i++) begin
      b_op[i]  = 4'($urandom_range(0, 12));
      b_a[i]   = $urandom;
      b_res[i] = $urandom;
      l = model_lat(b_op[i]);
      total += ((l == 0) ? 1 : l) + 2;
    end
    @(negedge clk);
    start = 1'b1; fpusrca = 1'b0; mode = 1'b0;
    fpucontrol = b_op[0]; fsrca = b_a[0]; fsrcb = ~b_a[0];
    for (int cyc = 0; cyc < total; cyc++) begin
      l   = model_lat(b_op[idx]);
      ill = (l == 0);
      if (ill) l = 1;
      rel = cyc - issue_cyc;
      unit_result = (rel == l) ? b_res[idx] : $urandom;
      #1;
      ndone += int'(done);
      checks++;
      if (stall !== (rel <= l) || done !== (rel == l + 1)) begin
        failures++;
        $display("FAIL b2b_timing op%0d rel=%0d got stall=%b done=%b exp=%b/%b",
                 idx, rel, stall, done, (rel <= l), (rel == l + 1));
      end
      if (rel == 1) begin
        checks++;
        if (unit_op !== b_op[idx] || unit_a !== b_a[idx] || unit_b !== ~b_a[idx]) begin
          failures++;
          $display("FAIL b2b_unit op%0d got=%h/%h/%h exp=%h/%h/%h",
                   idx, unit_op, unit_a, unit_b, b_op[idx], b_a[idx], ~b_a[idx]);
        end
      end
      if (rel == l + 1) begin
        m_result  = ill ? 32'd0 : b_res[idx];
        m_illegal = ill;
        checks++;
        if (result !== m_result || illegal !== m_illegal) begin
          failures++;
          $display("FAIL b2b_result op%0d got=%h/%b exp=%h/%b", idx, result, illegal, m_result, m_illegal);
        end
        idx++;
        issue_cyc = cyc + 1;
        if (idx < n) begin
          fpucontrol = b_op[idx]; fsrca = b_a[idx]; fsrcb = ~b_a[idx];
        end else begin
          idx   = n - 1;
          start = 1'b0;
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (ndone != n || stall !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count got dones=%0d stall=%b done=%b exp=%0d/0/0", ndone, stall, done, n);
    end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fcvt();
    test_illegal();
    test_ignored_starts();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
